// File: rtl/arbitro_escritura.sv
// arbitro_escritura: round-robin write-back arbiter driving the register-file mux select, address and write enable.
module arbitro_escritura #(
  parameter int ANCHO_DIR = 5
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [2:0]           Req,
  input  logic [ANCHO_DIR-1:0] Dir0,
  input  logic [ANCHO_DIR-1:0] Dir1,
  input  logic [ANCHO_DIR-1:0] Dir2,
  input  logic                 Bloqueo,
  output logic [1:0]           Ctrl,
  output logic [ANCHO_DIR-1:0] Dir_Esc,
  output logic                 We,
  output logic [2:0]           Gnt,
  output logic                 Ocupado
);
  typedef enum logic {REPOSO, ESCRIBE} estado_t;
  estado_t estado, estado_sig;
  logic [1:0] ult, ult_sig, c1, c2, ganador, ctrl_sig;
  logic [2:0] elegible, gnt_sig;
  logic [ANCHO_DIR-1:0] dir_w, dir_sig;
  logic hay, we_sig;
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      estado  <= REPOSO;
      ult     <= 2'd2;
      Ctrl    <= 2'b00;
      Dir_Esc <= '0;
      We      <= 1'b0;
      Gnt     <= 3'b000;
    end else begin
      estado  <= estado_sig;
      ult     <= ult_sig;
      Ctrl    <= ctrl_sig;
      Dir_Esc <= dir_sig;
      We      <= we_sig;
      Gnt     <= gnt_sig;
    end
  end
  // The source being written this cycle still holds Req, so it is masked out.
  always_comb begin
    elegible   = Bloqueo ? 3'b000 : Req & ~((estado == ESCRIBE) ? Gnt : 3'b000);
    hay        = |elegible;
    c1         = (ult == 2'd2) ? 2'd0 : ult + 2'd1;
    c2         = (ult == 2'd0) ? 2'd2 : ult - 2'd1;
    ganador    = elegible[c1] ? c1 : elegible[c2] ? c2 : ult;
    estado_sig = hay ? ESCRIBE : REPOSO;
    ult_sig    = hay ? ganador : ult;
  end
  always_comb begin
    dir_w    = (ganador == 2'd0) ? Dir0 : (ganador == 2'd1) ? Dir1 : Dir2;
    ctrl_sig = hay ? ganador : Ctrl;
    dir_sig  = hay ? dir_w : Dir_Esc;
    we_sig   = hay && (dir_w != '0);
    gnt_sig  = hay ? 3'b001 << ganador : 3'b000;
  end
  assign Ocupado = (estado == ESCRIBE);
endmodule

// File: tb/tb_arbitro_escritura.sv
// tb_arbitro_escritura: directed steps with a one-cycle-latency expected-output scoreboard.
module tb_arbitro_escritura;
  logic Clk = 1'b0, Rst_n = 1'b0, Bloqueo = 1'b0, We, Ocupado;
  logic [2:0] Req = 3'b000, Gnt;
  logic [4:0] Dir0 = 5'd7, Dir1 = 5'd9, Dir2 = 5'd21, Dir_Esc;
  logic [1:0] Ctrl;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [1:0] ctrl;
    logic [4:0] dir;
    logic       we;
    logic [2:0] gnt;
    logic       ocup;
  } exp_t;
  exp_t sb[$];
  always #5 Clk = ~Clk;
  arbitro_escritura #(.ANCHO_DIR(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Dir0(Dir0), .Dir1(Dir1), .Dir2(Dir2),
    .Bloqueo(Bloqueo), .Ctrl(Ctrl), .Dir_Esc(Dir_Esc), .We(We), .Gnt(Gnt), .Ocupado(Ocupado)
  );
  task automatic paso(input int n, input logic rst, input logic [2:0] req, input logic bloq,
                      input logic [1:0] c, input logic [4:0] d, input logic w,
                      input logic [2:0] g, input logic o);
    exp_t e;
    Rst_n = rst;
    Req = req;
    Bloqueo = bloq;
    sb.push_back('{c, d, w, g, o});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    checks += 5;
    assert (Ctrl === e.ctrl) else begin errors++; $error("FAIL step%0d ctrl got %b want %b", n, Ctrl, e.ctrl); end
    assert (Dir_Esc === e.dir) else begin errors++; $error("FAIL step%0d dir got %0d want %0d", n, Dir_Esc, e.dir); end
    assert (We === e.we) else begin errors++; $error("FAIL step%0d we got %b want %b", n, We, e.we); end
    assert (Gnt === e.gnt) else begin errors++; $error("FAIL step%0d gnt got %b want %b", n, Gnt, e.gnt); end
    assert (Ocupado === e.ocup) else begin errors++; $error("FAIL step%0d ocup got %b want %b", n, Ocupado, e.ocup); end
  endtask
  initial begin
    // reset
    paso(1, 0, 3'b000, 0, 2'b00, 5'd0, 0, 3'b000, 0);
    // all three request, each drops one cycle after its grant
    paso(2, 1, 3'b111, 0, 2'b00, 5'd7, 1, 3'b001, 1);
    paso(3, 1, 3'b111, 0, 2'b01, 5'd9, 1, 3'b010, 1);
    paso(4, 1, 3'b110, 0, 2'b10, 5'd21, 1, 3'b100, 1);
    paso(5, 1, 3'b100, 0, 2'b10, 5'd21, 0, 3'b000, 0);
    paso(6, 1, 3'b000, 0, 2'b10, 5'd21, 0, 3'b000, 0);
    // single request from source 0
    paso(7, 1, 3'b001, 0, 2'b00, 5'd7, 1, 3'b001, 1);
    paso(8, 1, 3'b000, 0, 2'b00, 5'd7, 0, 3'b000, 0);
    // sources 0 and 2 held high with last grant 0: alternate starting at 2
    paso(9, 1, 3'b101, 0, 2'b10, 5'd21, 1, 3'b100, 1);
    paso(10, 1, 3'b101, 0, 2'b00, 5'd7, 1, 3'b001, 1);
    paso(11, 1, 3'b101, 0, 2'b10, 5'd21, 1, 3'b100, 1);
    paso(12, 1, 3'b101, 0, 2'b00, 5'd7, 1, 3'b001, 1);
    paso(13, 1, 3'b000, 0, 2'b00, 5'd7, 0, 3'b000, 0);
    // write to register 0: granted but no write enable
    Dir1 = 5'd0;
    paso(14, 1, 3'b010, 0, 2'b01, 5'd0, 0, 3'b010, 1);
    paso(15, 1, 3'b000, 0, 2'b01, 5'd0, 0, 3'b000, 0);
    Dir1 = 5'd9;
    // stall for three cycles starting in the first grant cycle
    paso(16, 1, 3'b011, 0, 2'b00, 5'd7, 1, 3'b001, 1);
    paso(17, 1, 3'b011, 1, 2'b00, 5'd7, 0, 3'b000, 0);
    paso(18, 1, 3'b010, 1, 2'b00, 5'd7, 0, 3'b000, 0);
    paso(19, 1, 3'b010, 1, 2'b00, 5'd7, 0, 3'b000, 0);
    paso(20, 1, 3'b010, 0, 2'b01, 5'd9, 1, 3'b010, 1);
    paso(21, 1, 3'b000, 0, 2'b01, 5'd9, 0, 3'b000, 0);
    // reset during a write of source 2, then re-arbitration
    paso(22, 1, 3'b100, 0, 2'b10, 5'd21, 1, 3'b100, 1);
    paso(23, 0, 3'b100, 0, 2'b00, 5'd0, 0, 3'b000, 0);
    paso(24, 1, 3'b100, 0, 2'b10, 5'd21, 1, 3'b100, 1);
    paso(25, 1, 3'b000, 0, 2'b10, 5'd21, 0, 3'b000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
